// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier.
// Contents:
//   state_e      - controller states (IDLE, FEED, DRAIN, OUT)
//   CNT_W        - width of the beat and drain counters
//   MUL_W        - operand width the multiply-shift helper works in
//   fx_mul_shift - signed fixed-point multiply followed by arithmetic right shift
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Beat and drain counters share one width; it covers KMAX up to 65535.
    localparam int CNT_W = 16;

    // The multiplier sign-extends operands to this width, so NBITS may be at most 32.
    localparam int MUL_W = 32;

    // Full-precision signed product, shifted right by the fractional bit count.
    // The caller truncates the result to its own data width.
    function automatic logic signed [2*MUL_W-1:0] fx_mul_shift(
        input logic signed [MUL_W-1:0] a,
        input logic signed [MUL_W-1:0] b,
        input int                      dbits
    );
        logic signed [2*MUL_W-1:0] prod;
        prod = (2*MUL_W)'(a) * (2*MUL_W)'(b);
        return prod >>> dbits;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the systolic array.
// Every enabled cycle it multiplies the incoming x and w, adds the shifted and
// truncated product to its accumulator (wrapping), and forwards x to the right
// and w downwards through one register each.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   clr            - zero the accumulator (new job without accumulation)
//   en             - advance the pipeline and accumulate
//   x_in / x_out   - x operand from the left / to the right neighbour
//   w_in / w_out   - w operand from above / to the neighbour below
//   acc_out        - current accumulator value
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int DBITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [NBITS-1:0] x_in,
    input  logic signed [NBITS-1:0] w_in,
    output logic signed [NBITS-1:0] x_out,
    output logic signed [NBITS-1:0] w_out,
    output logic signed [NBITS-1:0] acc_out
);

    logic signed [NBITS-1:0] x_r;
    logic signed [NBITS-1:0] w_r;
    logic signed [NBITS-1:0] acc_r;

    // Pass registers and multiply-accumulate; clear takes priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= {NBITS{1'b0}};
            w_r   <= {NBITS{1'b0}};
            acc_r <= {NBITS{1'b0}};
        end else if (clr) begin
            acc_r <= {NBITS{1'b0}};
        end else if (en) begin
            x_r   <= x_in;
            w_r   <= w_in;
            acc_r <= acc_r + NBITS'(fx_mul_shift(MUL_W'(x_in), MUL_W'(w_in), DBITS));
        end
    end

    assign x_out   = x_r;
    assign w_out   = w_r;
    assign acc_out = acc_r;

endmodule

// File: rtl/systolic_matmul.sv
// Output-stationary systolic matrix multiplier.
// A job streams klen beats; each beat is one column of X (ROWS values) and one
// row of W (COLS values). PE(r,c) accumulates sum_k X[r][k]*W[k][c] in signed
// fixed point with DBITS fractional bits. After the last beat the array drains
// for ROWS+COLS-1 cycles, then the result is read out one row per handshake.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   cfg_val/cfg_rdy/cfg_klen/cfg_acc - job configuration (beat count, accumulate)
//   l_x_col_in/x_recv_val/x_recv_rdy - X column stream
//   t_w_row_in/w_recv_val/w_recv_rdy - W row stream
//   b_row_out/out_ridx/out_val/out_rdy - result row stream
//   busy                             - high whenever a job is in progress
module systolic_matmul
    import systolic_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int NBITS = 16,
    parameter int DBITS = 8,
    parameter int KMAX  = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_val,
    output logic                               cfg_rdy,
    input  logic [$clog2(KMAX+1)-1:0]          cfg_klen,
    input  logic                               cfg_acc,
    input  logic [ROWS-1:0][NBITS-1:0]         l_x_col_in,
    input  logic                               x_recv_val,
    output logic                               x_recv_rdy,
    input  logic [COLS-1:0][NBITS-1:0]         t_w_row_in,
    input  logic                               w_recv_val,
    output logic                               w_recv_rdy,
    output logic [COLS-1:0][NBITS-1:0]         b_row_out,
    output logic [$clog2(ROWS)-1:0]            out_ridx,
    output logic                               out_val,
    input  logic                               out_rdy,
    output logic                               busy
);

    localparam int RIDX_W    = $clog2(ROWS);
    localparam int DRAIN_LEN = ROWS + COLS - 1;

    state_e                state_r;
    state_e                next_state_s;
    logic [CNT_W-1:0]      klen_r;
    logic [CNT_W-1:0]      klen_sat_s;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic [CNT_W-1:0]      drain_cnt_r;
    logic [RIDX_W-1:0]     out_ridx_r;

    logic                  cfg_fire_s;
    logic                  beat_fire_s;
    logic                  out_fire_s;
    logic                  out_last_s;
    logic                  clr_s;
    logic                  en_s;

    logic [ROWS-1:0][NBITS-1:0]            x_feed_s;
    logic [COLS-1:0][NBITS-1:0]            w_feed_s;
    logic [ROWS-1:0][NBITS-1:0]            x_skew_s;
    logic [COLS-1:0][NBITS-1:0]            w_skew_s;
    logic [ROWS-1:0][COLS-1:0][NBITS-1:0]  x_in_s;
    logic [ROWS-1:0][COLS-1:0][NBITS-1:0]  w_in_s;
    logic [ROWS-1:0][COLS-1:0][NBITS-1:0]  x_out_s;
    logic [ROWS-1:0][COLS-1:0][NBITS-1:0]  w_out_s;
    logic [ROWS-1:0][COLS-1:0][NBITS-1:0]  acc_s;
    logic                                  unused_pass_s;

    assign cfg_fire_s  = (state_r == IDLE) && cfg_val;
    assign beat_fire_s = (state_r == FEED) && x_recv_val && w_recv_val;
    assign out_fire_s  = (state_r == OUT) && out_rdy;
    assign out_last_s  = (out_ridx_r == RIDX_W'(ROWS - 1));
    assign clr_s       = cfg_fire_s && !cfg_acc;
    assign en_s        = (state_r == FEED) || (state_r == DRAIN);

    // Requested beat counts above KMAX are clamped to KMAX.
    always_comb begin
        klen_sat_s = CNT_W'(cfg_klen);
        if (CNT_W'(cfg_klen) > CNT_W'(KMAX)) begin
            klen_sat_s = CNT_W'(KMAX);
        end else begin
            klen_sat_s = CNT_W'(cfg_klen);
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_fire_s) begin
                    if (klen_sat_s == CNT_W'(0)) begin
                        next_state_s = OUT;
                    end else begin
                        next_state_s = FEED;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FEED: begin
                if (beat_fire_s && (beat_cnt_r == klen_r - CNT_W'(1))) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = FEED;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == CNT_W'(DRAIN_LEN - 1)) begin
                    next_state_s = OUT;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            OUT: begin
                if (out_fire_s && out_last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Job length latch plus beat, drain and output-row counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            klen_r      <= {CNT_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            drain_cnt_r <= {CNT_W{1'b0}};
            out_ridx_r  <= {RIDX_W{1'b0}};
        end else if (cfg_fire_s) begin
            klen_r      <= klen_sat_s;
            beat_cnt_r  <= {CNT_W{1'b0}};
            drain_cnt_r <= {CNT_W{1'b0}};
            out_ridx_r  <= {RIDX_W{1'b0}};
        end else begin
            if (beat_fire_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
            if (state_r == DRAIN) begin
                drain_cnt_r <= drain_cnt_r + CNT_W'(1);
            end
            if (out_fire_s) begin
                out_ridx_r <= out_last_s ? {RIDX_W{1'b0}} : out_ridx_r + RIDX_W'(1);
            end
        end
    end

    // Bubble cycles (no accepted beat) push zeros, which add nothing to any accumulator.
    assign x_feed_s = beat_fire_s ? l_x_col_in : {(ROWS*NBITS){1'b0}};
    assign w_feed_s = beat_fire_s ? t_w_row_in : {(COLS*NBITS){1'b0}};

    // Row r of X is delayed r cycles so it meets column c of W inside PE(r,c).
    for (genvar r = 0; r < ROWS; r++) begin : g_x_skew
        if (r == 0) begin : g_direct
            assign x_skew_s[r] = x_feed_s[r];
        end else begin : g_delay
            logic [r-1:0][NBITS-1:0] sh_r;
            // Shift line for this row; advances every cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_r <= {(r*NBITS){1'b0}};
                end else begin
                    sh_r[0] <= x_feed_s[r];
                    for (int i = 1; i < r; i++) begin
                        sh_r[i] <= sh_r[i-1];
                    end
                end
            end
            assign x_skew_s[r] = sh_r[r-1];
        end
    end

    // Column c of W is delayed c cycles.
    for (genvar c = 0; c < COLS; c++) begin : g_w_skew
        if (c == 0) begin : g_direct
            assign w_skew_s[c] = w_feed_s[c];
        end else begin : g_delay
            logic [c-1:0][NBITS-1:0] sh_r;
            // Shift line for this column; advances every cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_r <= {(c*NBITS){1'b0}};
                end else begin
                    sh_r[0] <= w_feed_s[c];
                    for (int i = 1; i < c; i++) begin
                        sh_r[i] <= sh_r[i-1];
                    end
                end
            end
            assign w_skew_s[c] = sh_r[c-1];
        end
    end

    // PE grid: x flows right along a row, w flows down a column.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_xl
                assign x_in_s[r][c] = x_skew_s[r];
            end else begin : g_xp
                assign x_in_s[r][c] = x_out_s[r][c-1];
            end
            if (r == 0) begin : g_wt
                assign w_in_s[r][c] = w_skew_s[c];
            end else begin : g_wp
                assign w_in_s[r][c] = w_out_s[r-1][c];
            end

            systolic_pe #(
                .NBITS (NBITS),
                .DBITS (DBITS)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr_s),
                .en      (en_s),
                .x_in    (x_in_s[r][c]),
                .w_in    (w_in_s[r][c]),
                .x_out   (x_out_s[r][c]),
                .w_out   (w_out_s[r][c]),
                .acc_out (acc_s[r][c])
            );
        end
    end

    // The right-most x and bottom w pass registers have no consumer.
    assign unused_pass_s = ^{x_out_s, w_out_s};

    assign cfg_rdy    = (state_r == IDLE);
    assign busy       = (state_r != IDLE);
    assign x_recv_rdy = (state_r == FEED);
    assign w_recv_rdy = (state_r == FEED);
    assign out_val    = (state_r == OUT);
    assign out_ridx   = out_ridx_r;
    // Accumulators are frozen in OUT, so the selected row is stable while stalled.
    assign b_row_out  = (state_r == OUT) ? acc_s[out_ridx_r] : {(COLS*NBITS){1'b0}};

endmodule

// File: tb/tb_systolic_matmul.sv
module tb_systolic_matmul;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int NBITS = 16;
    localparam int DBITS = 8;
    localparam int KMAX  = 255;
    localparam int KW    = $clog2(KMAX + 1);

    typedef logic [1:0][15:0] vec2_t;

    typedef struct {
        int             klen;
        bit             acc;
        int             gap;
        int             stall;
        vec2_t          x [2];
        vec2_t          w [2];
        vec2_t          exp_row [2];
    } tvec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_val;
    logic              cfg_rdy;
    logic [KW-1:0]     cfg_klen;
    logic              cfg_acc;
    vec2_t             l_x_col_in;
    logic              x_recv_val;
    logic              x_recv_rdy;
    vec2_t             t_w_row_in;
    logic              w_recv_val;
    logic              w_recv_rdy;
    vec2_t             b_row_out;
    logic [0:0]        out_ridx;
    logic              out_val;
    logic              out_rdy;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mdl [2][2];
    vec2_t       qx [$];
    vec2_t       qw [$];
    tvec_t       tbl [6];

    systolic_matmul #(
        .ROWS(ROWS), .COLS(COLS), .NBITS(NBITS), .DBITS(DBITS), .KMAX(KMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_klen(cfg_klen), .cfg_acc(cfg_acc),
        .l_x_col_in(l_x_col_in), .x_recv_val(x_recv_val), .x_recv_rdy(x_recv_rdy),
        .t_w_row_in(t_w_row_in), .w_recv_val(w_recv_val), .w_recv_rdy(w_recv_rdy),
        .b_row_out(b_row_out), .out_ridx(out_ridx), .out_val(out_val), .out_rdy(out_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec2_t mk(input logic [15:0] e0, input logic [15:0] e1);
        vec2_t v;
        v[0] = e0;
        v[1] = e1;
        return v;
    endfunction

    // Fixed-point product: value = raw / 256, result rounded toward minus infinity, kept mod 2^16.
    function automatic logic [15:0] fx(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = (p - ((p % 256 + 256) % 256)) / 256;
        return p[15:0];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                mdl[r][c] = 16'h0000;
    endtask

    // Runs one job from the queues qx/qw; gap = bubble cycles before each beat.
    task automatic run_job(input int klen, input bit acc, input int gap, input int stall,
                           output vec2_t got [2]);
        int    k;
        int    d;
        int    guard;
        vec2_t snap;
        check("cfg_rdy_idle", cfg_rdy, 1);
        cfg_val  = 1'b1;
        cfg_klen = KW'(klen);
        cfg_acc  = acc;
        tick();
        cfg_val  = 1'b0;
        cfg_klen = KW'($urandom);
        cfg_acc  = $urandom_range(0, 1);
        if (!acc) model_clear();
        k = 0;
        guard = 0;
        while (k < klen && guard < 2000) begin
            for (int g = 0; g < gap; g++) begin
                x_recv_val = 1'b0;
                w_recv_val = 1'b1;
                l_x_col_in = vec2_t'($urandom);
                t_w_row_in = vec2_t'($urandom);
                tick();
                check("gap_still_feed", x_recv_rdy, 1);
                guard++;
            end
            x_recv_val = 1'b1;
            w_recv_val = 1'b1;
            l_x_col_in = qx[k];
            t_w_row_in = qw[k];
            check("beat_rdy", w_recv_rdy, 1);
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    mdl[r][c] = mdl[r][c] + fx(qx[k][r], qw[k][c]);
            tick();
            k++;
            guard++;
        end
        x_recv_val = 1'b0;
        w_recv_val = 1'b0;
        d = 0;
        while (!out_val && d < 20) begin
            check("drain_busy", {busy, x_recv_rdy, cfg_rdy}, 3'b100);
            tick();
            d++;
        end
        check("drain_len", d, (klen == 0) ? 0 : ROWS + COLS - 1);
        for (int r = 0; r < 2; r++) begin
            check("out_val", out_val, 1);
            check("out_ridx", out_ridx, r);
            snap = b_row_out;
            for (int s = 0; s < stall; s++) begin
                tick();
                check("stall_val", out_val, 1);
                check("stall_ridx", out_ridx, r);
                check("stall_data", b_row_out, snap);
            end
            got[r] = b_row_out;
            out_rdy = 1'b1;
            tick();
            out_rdy = 1'b0;
        end
        check("done_idle", {busy, cfg_rdy, out_val}, 3'b010);
    endtask

    initial begin
        vec2_t got [2];
        int    klen;
        bit    acc;

        // Directed table: stimulus and the expected result rows.
        tbl[0] = '{klen: 2, acc: 1'b0, gap: 0, stall: 0,
                   x: '{mk(16'h0100, 16'h0000), mk(16'h0000, 16'h0100)},
                   w: '{mk(16'h0200, 16'h0300), mk(16'h0400, 16'h0500)},
                   exp_row: '{mk(16'h0200, 16'h0300), mk(16'h0400, 16'h0500)}};
        tbl[1] = tbl[0];
        tbl[1].gap = 2;
        tbl[2] = tbl[0];
        tbl[2].acc = 1'b1;
        tbl[2].exp_row = '{mk(16'h0400, 16'h0600), mk(16'h0800, 16'h0A00)};
        tbl[3] = tbl[0];
        tbl[4] = '{klen: 0, acc: 1'b0, gap: 0, stall: 0,
                   x: '{mk(16'h0000, 16'h0000), mk(16'h0000, 16'h0000)},
                   w: '{mk(16'h0000, 16'h0000), mk(16'h0000, 16'h0000)},
                   exp_row: '{mk(16'h0000, 16'h0000), mk(16'h0000, 16'h0000)}};
        tbl[5] = '{klen: 1, acc: 1'b0, gap: 0, stall: 5,
                   x: '{mk(16'h7F00, 16'h0000), mk(16'h0000, 16'h0000)},
                   w: '{mk(16'h0200, 16'h0000), mk(16'h0000, 16'h0000)},
                   exp_row: '{mk(16'hFE00, 16'h0000), mk(16'h0000, 16'h0000)}};

        rst = 1'b1;
        cfg_val = 1'b0; cfg_klen = '0; cfg_acc = 1'b0;
        l_x_col_in = '0; x_recv_val = 1'b0;
        t_w_row_in = '0; w_recv_val = 1'b0;
        out_rdy = 1'b0;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        check("rst_cfg_rdy", cfg_rdy, 1);
        check("rst_x_rdy", x_recv_rdy, 0);
        check("rst_w_rdy", w_recv_rdy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_out_ridx", out_ridx, 0);
        check("rst_busy", busy, 0);
        check("rst_b_row", b_row_out, 0);

        for (int i = 0; i < 6; i++) begin
            qx.delete();
            qw.delete();
            for (int k = 0; k < tbl[i].klen; k++) begin
                qx.push_back(tbl[i].x[k]);
                qw.push_back(tbl[i].w[k]);
            end
            run_job(tbl[i].klen, tbl[i].acc, tbl[i].gap, tbl[i].stall, got);
            check($sformatf("tbl%0d_row0", i), got[0], tbl[i].exp_row[0]);
            check($sformatf("tbl%0d_row1", i), got[1], tbl[i].exp_row[1]);
        end

        // Reset while draining, then an accumulate job must see clean accumulators.
        tick();
        cfg_val = 1'b1; cfg_klen = KW'(2); cfg_acc = 1'b0;
        tick();
        cfg_val = 1'b0;
        for (int k = 0; k < 2; k++) begin
            x_recv_val = 1'b1; w_recv_val = 1'b1;
            l_x_col_in = tbl[0].x[k]; t_w_row_in = tbl[0].w[k];
            tick();
        end
        x_recv_val = 1'b0; w_recv_val = 1'b0;
        check("pre_rst_drain", {busy, x_recv_rdy, out_val}, 3'b100);
        rst = 1'b1;
        x_recv_val = 1'b1; w_recv_val = 1'b1;
        tick();
        rst = 1'b0;
        x_recv_val = 1'b0; w_recv_val = 1'b0;
        check("rst_drain_busy", busy, 0);
        check("rst_drain_cfg_rdy", cfg_rdy, 1);
        check("rst_drain_out_val", out_val, 0);
        tick();
        check("rst_drain_quiet", {busy, out_val, x_recv_rdy}, 3'b000);
        model_clear();
        qx.delete(); qw.delete();
        for (int k = 0; k < 2; k++) begin
            qx.push_back(tbl[0].x[k]);
            qw.push_back(tbl[0].w[k]);
        end
        run_job(2, 1'b1, 0, 1, got);
        check("post_rst_row0", got[0], tbl[0].exp_row[0]);
        check("post_rst_row1", got[1], tbl[0].exp_row[1]);

        // Randomized jobs against the behavioural matrix model.
        for (int j = 0; j < 10; j++) begin
            klen = $urandom_range(1, 6);
            acc  = $urandom_range(0, 1);
            qx.delete(); qw.delete();
            for (int k = 0; k < klen; k++) begin
                qx.push_back(vec2_t'($urandom));
                qw.push_back(vec2_t'($urandom));
            end
            run_job(klen, acc, $urandom_range(0, 2), $urandom_range(0, 2), got);
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    check($sformatf("rand%0d_r%0dc%0d", j, r, c), got[r][c], mdl[r][c]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
